// File: rtl/toy_decode_ibuf_if.sv
// ----------------------------------------------------------------------------
// toy_decode_ibuf_if
// Bundle of the fetch->ibuf and ibuf->decode lanes plus the cancel pulse and
// occupancy readback.
//   slave  : the instruction buffer (consumes in_*, flush_en, out_rdy;
//            drives in_rdy, out_*, ibuf_count)
//   master : the fetch/decode environment around the buffer
// ----------------------------------------------------------------------------
interface toy_decode_ibuf_if #(
  parameter int DEPTH             = 16,
  parameter int INST_READ_CHANNEL = 4,
  parameter int INST_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int INST_IDX_WIDTH    = 8,
  parameter int CNT_WIDTH         = $clog2(DEPTH) + 1
);
  logic                                               flush_en;
  logic [INST_READ_CHANNEL-1:0]                       in_vld;
  logic [INST_READ_CHANNEL-1:0]                       in_rdy;
  logic [INST_READ_CHANNEL-1:0][INST_WIDTH-1:0]       in_pld;
  logic [INST_READ_CHANNEL-1:0][ADDR_WIDTH-1:0]       in_pc;
  logic [INST_READ_CHANNEL-1:0][INST_IDX_WIDTH-1:0]   in_idx;
  logic [INST_READ_CHANNEL-1:0]                       out_vld;
  logic [INST_READ_CHANNEL-1:0]                       out_rdy;
  logic [INST_READ_CHANNEL-1:0][INST_WIDTH-1:0]       out_pld;
  logic [INST_READ_CHANNEL-1:0][ADDR_WIDTH-1:0]       out_pc;
  logic [INST_READ_CHANNEL-1:0][INST_IDX_WIDTH-1:0]   out_idx;
  logic [CNT_WIDTH-1:0]                               ibuf_count;

  modport slave (
    input  flush_en, in_vld, in_pld, in_pc, in_idx, out_rdy,
    output in_rdy, out_vld, out_pld, out_pc, out_idx, ibuf_count
  );

  modport master (
    output flush_en, in_vld, in_pld, in_pc, in_idx, out_rdy,
    input  in_rdy, out_vld, out_pld, out_pc, out_idx, ibuf_count
  );
endinterface

// File: rtl/toy_decode_ibuf.sv
// ----------------------------------------------------------------------------
// toy_decode_ibuf
// Instruction buffer between the fetch output stage and decode. Accepted
// fetch lanes are compacted into a circular FIFO and presented in order,
// left-aligned from lane 0, to decode.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : toy_decode_ibuf_if.slave
//            in_vld/in_rdy/in_pld/in_pc/in_idx  per-lane fetch input
//            out_vld/out_rdy/out_pld/out_pc/out_idx per-lane decode output
//            flush_en  cancel pulse, discards all contents
//            ibuf_count current occupancy
// ----------------------------------------------------------------------------
module toy_decode_ibuf #(
  parameter int DEPTH             = 16,
  parameter int INST_READ_CHANNEL = 4,
  parameter int INST_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int INST_IDX_WIDTH    = 8,
  parameter int CNT_WIDTH         = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  toy_decode_ibuf_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH    = INST_READ_CHANNEL;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [CNT_WIDTH-1:0] free;
  logic [CNT_WIDTH-1:0] n_enq;
  logic [CNT_WIDTH-1:0] n_deq;
  logic [CH-1:0]        en_in;
  logic [CH-1:0]        hs;
  logic [PTR_W-1:0]     wr_slot [CH];

  // Storage is intentionally not reset.
  logic [INST_WIDTH-1:0]     mem_pld [DEPTH];
  logic [ADDR_WIDTH-1:0]     mem_pc  [DEPTH];
  logic [INST_IDX_WIDTH-1:0] mem_idx [DEPTH];

  // Only the registered count feeds ready: entries freed this cycle are not
  // reusable until next cycle, which keeps in_rdy free of any out_rdy path.
  assign free  = CNT_WIDTH'(DEPTH) - count_q;
  assign en_in = bus.in_vld & bus.in_rdy;
  assign hs    = bus.out_vld & bus.out_rdy;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
    logic [PTR_W-1:0] rd_slot;
    assign rd_slot            = rd_ptr_q + PTR_W'(gi);
    assign bus.in_rdy[gi]     = (free > CNT_WIDTH'(gi)) && !bus.flush_en;
    assign bus.out_vld[gi]    = (count_q > CNT_WIDTH'(gi)) && !bus.flush_en;
    assign bus.out_pld[gi]    = mem_pld[rd_slot];
    assign bus.out_pc[gi]     = mem_pc[rd_slot];
    assign bus.out_idx[gi]    = mem_idx[rd_slot];
  end

  assign bus.ibuf_count = count_q;

  // Compaction: each accepted lane goes to wr_ptr plus the number of
  // accepted lanes below it, so sparse valid patterns pack with no holes.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < CH; i++) begin
      wr_slot[i] = wr_ptr_q + n_enq[PTR_W-1:0];
      if (en_in[i]) n_enq = n_enq + CNT_WIDTH'(1);
    end
  end

  // Dequeue only the unbroken run of handshakes starting at lane 0; a
  // handshake above a gap is dropped so the FIFO order is never violated.
  always_comb begin
    logic run;
    run   = 1'b1;
    n_deq = '0;
    for (int i = 0; i < CH; i++) begin
      if (run && hs[i]) n_deq = n_deq + CNT_WIDTH'(1);
      else              run   = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_enq[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + n_deq[PTR_W-1:0];
    count_d  = count_q + n_enq - n_deq;
    if (bus.flush_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // en_in is already zero during flush because in_rdy is forced low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (en_in[i]) begin
        mem_pld[wr_slot[i]] <= bus.in_pld[i];
        mem_pc[wr_slot[i]]  <= bus.in_pc[i];
        mem_idx[wr_slot[i]] <= bus.in_idx[i];
      end
    end
  end

endmodule

// File: tb/tb_toy_decode_ibuf.sv
module tb_toy_decode_ibuf;
  localparam int DEPTH = 16;
  localparam int CH    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc_no = 0;

  toy_decode_ibuf_if #(.DEPTH(DEPTH), .INST_READ_CHANNEL(CH), .INST_WIDTH(32),
                       .ADDR_WIDTH(32), .INST_IDX_WIDTH(8), .CNT_WIDTH(CW)) bus ();

  toy_decode_ibuf #(.DEPTH(DEPTH), .INST_READ_CHANNEL(CH), .INST_WIDTH(32),
                    .ADDR_WIDTH(32), .INST_IDX_WIDTH(8), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pld;
    logic [31:0] pc;
    logic [7:0]  idx;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Queue-level reference: the buffer is an ordered list of instructions.
  // Checked on every falling edge, then advanced to the post-edge state.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      automatic logic [3:0] er;
      automatic logic [3:0] ev;
      automatic logic [3:0] hsk;
      automatic int sz = q.size();
      automatic int n = 0;
      automatic int nenq = 0;
      for (int i = 0; i < CH; i++) begin
        er[i] = ((DEPTH - sz) > i) && !bus.flush_en;
        ev[i] = (sz > i) && !bus.flush_en;
      end
      chk("in_rdy", 64'(bus.in_rdy), 64'(er));
      chk("out_vld", 64'(bus.out_vld), 64'(ev));
      chk("ibuf_count", 64'(bus.ibuf_count), 64'(sz));
      chk("count_le_depth", 64'(bus.ibuf_count <= CW'(DEPTH)), 64'(1));
      for (int i = 0; i < CH; i++) begin
        if (ev[i]) begin
          chk($sformatf("out_pc[%0d]", i), 64'(bus.out_pc[i]), 64'(q[i].pc));
          chk($sformatf("out_pld[%0d]", i), 64'(bus.out_pld[i]), 64'(q[i].pld));
          chk($sformatf("out_idx[%0d]", i), 64'(bus.out_idx[i]), 64'(q[i].idx));
        end
      end
      hsk = ev & bus.out_rdy;
      while (n < CH && hsk[n]) n++;
      if (n < CH && (hsk >> n) != 4'b0)
        $display("warning: out_rdy gap, handshake above lane %0d ignored (hs=%b)", n, hsk);
      if (bus.flush_en) begin
        q.delete();
        n = 0;
      end else begin
        for (int i = 0; i < n; i++) void'(q.pop_front());
        for (int i = 0; i < CH; i++) begin
          if (bus.in_vld[i] && er[i]) begin
            q.push_back('{pld: bus.in_pld[i], pc: bus.in_pc[i], idx: bus.in_idx[i]});
            nenq++;
          end
        end
      end
      $display("cyc %0d: vld=%b rdy=%b flush=%b enq=%0d deq=%0d count->%0d",
               cyc_no, bus.in_vld, bus.out_rdy, bus.flush_en, nenq, n, q.size());
      cyc_no++;
    end
  end

  function automatic logic [3:0][31:0] pc4(input logic [31:0] base);
    return {base + 32'd12, base + 32'd8, base + 32'd4, base};
  endfunction

  task automatic set_in(input logic [3:0] vld, input logic [3:0][31:0] pcs,
                        input logic [7:0] idx0, input logic [3:0] rdy, input logic fl);
    bus.in_vld   = vld;
    bus.out_rdy  = rdy;
    bus.flush_en = fl;
    for (int i = 0; i < CH; i++) begin
      bus.in_pc[i]  = pcs[i];
      bus.in_pld[i] = ~pcs[i] ^ 32'h5A5A_0000;
      bus.in_idx[i] = idx0 + 8'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.in_vld   = '0;
    bus.out_rdy  = '0;
    bus.flush_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(4'b0, pc4(32'h0), 8'h0, 4'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    #1;
    chk("rst in_rdy", 64'(bus.in_rdy), 64'hF);
    chk("rst out_vld", 64'(bus.out_vld), 64'h0);
    chk("rst count", 64'(bus.ibuf_count), 64'h0);

    // Four-lane enqueue, in-order presentation
    set_in(4'b1111, pc4(32'h100), 8'h10, 4'b0000, 1'b0);
    tick(); #1;
    chk("enq4 out_vld", 64'(bus.out_vld), 64'hF);
    chk("enq4 pc0", 64'(bus.out_pc[0]), 64'h100);
    chk("enq4 pc1", 64'(bus.out_pc[1]), 64'h104);
    chk("enq4 pc2", 64'(bus.out_pc[2]), 64'h108);
    chk("enq4 pc3", 64'(bus.out_pc[3]), 64'h10C);
    chk("enq4 count", 64'(bus.ibuf_count), 64'd4);
    set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1111, 1'b0);
    tick();

    // Sparse input compacts to lanes 0-1
    set_in(4'b1010, {32'h208, 32'hDEAD, 32'h200, 32'hBEEF}, 8'h20, 4'b0000, 1'b0);
    tick(); #1;
    chk("sparse out_vld", 64'(bus.out_vld), 64'h3);
    chk("sparse pc0", 64'(bus.out_pc[0]), 64'h200);
    chk("sparse pc1", 64'(bus.out_pc[1]), 64'h208);
    chk("sparse count", 64'(bus.ibuf_count), 64'd2);
    set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1111, 1'b0);
    tick();

    // Fill to 14, then to full, then dequeue while full
    set_in(4'b1111, pc4(32'h300), 8'h30, 4'b0, 1'b0); tick();
    set_in(4'b1111, pc4(32'h310), 8'h34, 4'b0, 1'b0); tick();
    set_in(4'b1111, pc4(32'h320), 8'h38, 4'b0, 1'b0); tick();
    set_in(4'b0011, pc4(32'h330), 8'h3C, 4'b0, 1'b0); tick(); #1;
    chk("cnt14 in_rdy", 64'(bus.in_rdy), 64'h3);
    set_in(4'b1111, pc4(32'h340), 8'h40, 4'b0, 1'b0); tick(); #1;
    chk("full count", 64'(bus.ibuf_count), 64'd16);
    chk("full in_rdy", 64'(bus.in_rdy), 64'h0);
    set_in(4'b1111, pc4(32'h350), 8'h44, 4'b1111, 1'b0); #1;
    chk("full+deq in_rdy", 64'(bus.in_rdy), 64'h0);
    tick(); #1;
    chk("after deq in_rdy", 64'(bus.in_rdy), 64'hF);
    chk("after deq count", 64'(bus.ibuf_count), 64'd12);
    repeat (3) begin
      set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1111, 1'b0); tick();
    end

    // Advance pointers from 6 to 14, then straddle the wrap boundary
    repeat (2) begin
      set_in(4'b1111, pc4(32'h380), 8'h50, 4'b0000, 1'b0); tick();
      set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1111, 1'b0); tick();
    end
    set_in(4'b1111, pc4(32'h700), 8'hA0, 4'b0000, 1'b0); tick(); #1;
    chk("wrap idx0", 64'(bus.out_idx[0]), 64'hA0);
    chk("wrap idx1", 64'(bus.out_idx[1]), 64'hA1);
    chk("wrap idx2", 64'(bus.out_idx[2]), 64'hA2);
    chk("wrap idx3", 64'(bus.out_idx[3]), 64'hA3);
    chk("wrap pc3", 64'(bus.out_pc[3]), 64'h70C);
    set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1111, 1'b0); tick(); #1;
    chk("wrap drained", 64'(bus.ibuf_count), 64'd0);

    // Out-of-order ready: only lane 0 dequeues
    set_in(4'b1111, pc4(32'h400), 8'h60, 4'b0000, 1'b0); tick();
    set_in(4'b0000, pc4(32'h0), 8'h0, 4'b1101, 1'b0); tick(); #1;
    chk("ooo count", 64'(bus.ibuf_count), 64'd3);
    chk("ooo pc0", 64'(bus.out_pc[0]), 64'h404);

    // Flush with count 9 and all lanes valid
    set_in(4'b1111, pc4(32'h500), 8'h70, 4'b0000, 1'b0); tick();
    set_in(4'b0011, pc4(32'h510), 8'h74, 4'b0000, 1'b0); tick(); #1;
    chk("preflush count", 64'(bus.ibuf_count), 64'd9);
    set_in(4'b1111, pc4(32'h520), 8'h78, 4'b1111, 1'b1); #1;
    chk("flush in_rdy", 64'(bus.in_rdy), 64'h0);
    chk("flush out_vld", 64'(bus.out_vld), 64'h0);
    tick(); #1;
    chk("postflush count", 64'(bus.ibuf_count), 64'd0);
    chk("postflush out_vld", 64'(bus.out_vld), 64'h0);
    chk("postflush in_rdy", 64'(bus.in_rdy), 64'hF);
    set_in(4'b1111, pc4(32'h600), 8'h80, 4'b0000, 1'b0); tick(); #1;
    chk("postflush pc0", 64'(bus.out_pc[0]), 64'h600);

    // Mixed traffic, checked cycle by cycle against the queue model
    for (int k = 0; k < 80; k++) begin
      automatic logic [3:0][31:0] pcs;
      for (int i = 0; i < CH; i++) pcs[i] = $urandom;
      set_in(4'($urandom), pcs, 8'($urandom), 4'($urandom),
             ($urandom_range(0, 24) == 0));
      tick();
    end

    // Asynchronous reset mid-operation
    set_in(4'b1111, pc4(32'h800), 8'h90, 4'b0000, 1'b0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", 64'(bus.ibuf_count), 64'd0);
    chk("async rst out_vld", 64'(bus.out_vld), 64'h0);
    chk("async rst in_rdy", 64'(bus.in_rdy), 64'hF);
    @(posedge clk); #1 rst_n = 1'b1;
    set_in(4'b0101, pc4(32'h900), 8'hB0, 4'b0000, 1'b0); tick(); #1;
    chk("post rst pc0", 64'(bus.out_pc[0]), 64'h900);
    chk("post rst pc1", 64'(bus.out_pc[1]), 64'h908);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
